// File: rtl/pipe_mem_io.sv
// MEM stage data RAM plus memory-mapped I/O: synchronised inputs,
// registered outputs, a cycle counter and a sticky misaligned-store flag.
module pipe_mem_io #(
    parameter int DEPTH_LOG2 = 5
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        mwmem,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    input  logic [31:0] in_port0,
    input  logic [31:0] in_port1,
    output logic [31:0] mmo,
    output logic [31:0] out_port0,
    output logic [31:0] out_port1,
    output logic [31:0] out_port2,
    output logic        merr
);

    localparam int WORDS = 1 << DEPTH_LOG2;

    localparam logic [4:0] SEL_IN0  = 5'd0;
    localparam logic [4:0] SEL_IN1  = 5'd1;
    localparam logic [4:0] SEL_OUT2 = 5'd2;
    localparam logic [4:0] SEL_CNT  = 5'd3;
    localparam logic [4:0] SEL_STAT = 5'd4;

    logic [31:0] ram_q [WORDS];

    logic [31:0] in0_s1_q, in0_s2_q, in1_s1_q, in1_s2_q;
    logic [31:0] out0_q, out0_d;
    logic [31:0] out1_q, out1_d;
    logic [31:0] out2_q, out2_d;
    logic [31:0] cnt_q, cnt_d;
    logic        merr_q, merr_d;
    logic [7:0]  fault_q, fault_d;

    logic [DEPTH_LOG2-1:0] ram_idx;
    logic [4:0]            io_sel;
    logic                  is_io;
    logic                  aligned;
    logic                  st_ok;
    logic                  st_bad;
    logic                  st_ram;

    logic unused_malu;
    assign unused_malu = ^malu[31:8];

    assign ram_idx = malu[DEPTH_LOG2+1:2];
    assign io_sel  = malu[6:2];
    assign is_io   = malu[7];
    assign aligned = (malu[1:0] == 2'b00);
    assign st_ok   = mwmem && aligned;
    assign st_bad  = mwmem && !aligned;
    assign st_ram  = st_ok && !is_io;

    always_comb begin
        out0_d  = out0_q;
        out1_d  = out1_q;
        out2_d  = out2_q;
        cnt_d   = cnt_q + 32'd1;
        merr_d  = merr_q;
        fault_d = fault_q;
        if (st_ok && is_io) begin
            case (io_sel)
                SEL_IN0:  out0_d = mb;
                SEL_IN1:  out1_d = mb;
                SEL_OUT2: out2_d = mb;
                SEL_CNT:  cnt_d  = mb;
                SEL_STAT: begin
                    merr_d  = 1'b0;
                    fault_d = 8'h00;
                end
                default: ;
            endcase
        end
        // Only the first misaligned store is recorded until cleared.
        if (st_bad && !merr_q) begin
            merr_d  = 1'b1;
            fault_d = malu[7:0];
        end
    end

    always_comb begin
        mmo = 32'h0;
        if (!is_io) begin
            mmo = ram_q[ram_idx];
        end else begin
            case (io_sel)
                SEL_IN0:  mmo = in0_s2_q;
                SEL_IN1:  mmo = in1_s2_q;
                SEL_OUT2: mmo = out2_q;
                SEL_CNT:  mmo = cnt_q;
                SEL_STAT: mmo = {merr_q, 23'b0, fault_q};
                default:  mmo = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            in0_s1_q <= 32'h0;
            in0_s2_q <= 32'h0;
            in1_s1_q <= 32'h0;
            in1_s2_q <= 32'h0;
            out0_q   <= 32'h0;
            out1_q   <= 32'h0;
            out2_q   <= 32'h0;
            cnt_q    <= 32'h0;
            merr_q   <= 1'b0;
            fault_q  <= 8'h00;
        end else begin
            in0_s1_q <= in_port0;
            in0_s2_q <= in0_s1_q;
            in1_s1_q <= in_port1;
            in1_s2_q <= in1_s1_q;
            out0_q   <= out0_d;
            out1_q   <= out1_d;
            out2_q   <= out2_d;
            cnt_q    <= cnt_d;
            merr_q   <= merr_d;
            fault_q  <= fault_d;
        end
    end

    // RAM has no reset; a store coinciding with reset is dropped.
    always_ff @(posedge clock) begin
        if (resetn && st_ram) begin
            ram_q[ram_idx] <= mb;
        end
    end

    assign out_port0 = out0_q;
    assign out_port1 = out1_q;
    assign out_port2 = out2_q;
    assign merr      = merr_q;

endmodule
